// File: rtl/prbs_checker.sv
// PRBS sink for the x^4+x+1 Fibonacci LFSR stream: self-syncs, locks, counts errors.
// Ports: clk, reset, in_valid, in_bit, clear_errs -> locked, err_pulse, err_count.
module prbs_checker #(
  parameter int              WIDTH        = 4,
  parameter logic [WIDTH-1:0] TAP_MASK    = 4'b1001,
  parameter int              LOCK_COUNT   = 8,
  parameter int              UNLOCK_COUNT = 4,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_errs,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);

  localparam logic [FW-1:0]    FILL_MAX    = FW'(WIDTH);
  localparam logic [MW-1:0]    LOCK_LAST   = MW'(LOCK_COUNT - 1);
  localparam logic [UW-1:0]    UNLOCK_LAST = UW'(UNLOCK_COUNT - 1);
  localparam logic [CNT_W-1:0] ERR_MAX     = '1;

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hist;
  logic [FW-1:0]    fill;
  logic [MW-1:0]    match_cnt;
  logic [UW-1:0]    miss_cnt;

  logic pred;
  logic mismatch;

  always_comb begin
    pred     = ^(hist & TAP_MASK);
    mismatch = in_bit ^ pred;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (clear_errs)
        err_count <= '0;
      if (in_valid) begin
        unique case (state)
          SEARCH: begin
            hist <= {hist[WIDTH-2:0], in_bit};
            if (fill < FILL_MAX) begin
              fill <= fill + 1'b1;
            end else if (!mismatch && hist != '0) begin
              if (match_cnt == LOCK_LAST) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              // an all-zero window predicts zero forever; never trust it
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // free-running local LFSR: received errors never enter hist
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (!clear_errs && err_count != ERR_MAX)
                err_count <= err_count + 1'b1;
              if (miss_cnt == UNLOCK_LAST) begin
                state     <= SEARCH;
                locked    <= 1'b0;
                hist      <= '0;
                fill      <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                hist     <= {hist[WIDTH-2:0], pred};
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              hist     <= {hist[WIDTH-2:0], pred};
              miss_cnt <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker against a queue-based reference model.
// Two instances share stimulus: default CNT_W=16 and CNT_W=4 for saturation.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_bit;
  logic        clear_errs;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        locked4;
  logic        err_pulse4;
  logic [3:0]  err_count4;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .clear_errs (clear_errs),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  prbs_checker #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .clear_errs (clear_errs),
    .locked     (locked4),
    .err_pulse  (err_pulse4),
    .err_count  (err_count4)
  );

  // generator output from seed 0001, one period
  int seqtab [15] = '{1,1,1,0,1,0,1,1,0,0,1,0,0,0,1};
  int gi;

  function automatic bit nb();
    bit b;
    b = seqtab[gi % 15][0];
    gi++;
    return b;
  endfunction

  // reference model: window of last 4 bits, oldest at index 0
  bit mq[$];
  int m_run, m_miss, m_err16, m_err4;
  bit m_lock, m_pulse;

  task automatic model_reset();
    mq.delete();
    m_run = 0; m_miss = 0; m_err16 = 0; m_err4 = 0;
    m_lock = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit c);
    bit p;
    bit z;
    m_pulse = 0;
    if (c) begin
      m_err16 = 0;
      m_err4  = 0;
    end
    if (v) begin
      if (!m_lock) begin
        if (mq.size() < 4) begin
          mq.push_back(b);
        end else begin
          p = mq[3] ^ mq[0];
          z = (mq[0] | mq[1] | mq[2] | mq[3]) == 1'b0;
          if (b == p && !z) m_run++;
          else m_run = 0;
          mq.push_back(b);
          void'(mq.pop_front());
          if (m_run == 8) begin
            m_lock = 1; m_run = 0; m_miss = 0;
          end
        end
      end else begin
        p = mq[3] ^ mq[0];
        mq.push_back(p);
        void'(mq.pop_front());
        if (b != p) begin
          m_pulse = 1;
          if (!c) begin
            if (m_err16 < 65535) m_err16++;
            if (m_err4 < 15) m_err4++;
          end
          m_miss++;
          if (m_miss == 4) begin
            m_lock = 0; mq.delete(); m_run = 0; m_miss = 0;
          end
        end else begin
          m_miss = 0;
        end
      end
    end
  endtask

  function automatic logic [21:0] expv();
    return {m_lock, m_pulse, 16'(m_err16), 4'(m_err4)};
  endfunction

  function automatic logic [21:0] gotv();
    return {locked & locked4, err_pulse & err_pulse4, err_count, err_count4};
  endfunction

  task automatic drive(input bit v, input bit b, input bit c);
    in_valid   = v;
    in_bit     = b;
    clear_errs = c;
    model_step(v, b, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_errs = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    gi = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_bit = 1'b1; clear_errs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    model_reset();
    gi = 0;
    n_checks++;
    if ({locked, err_pulse, err_count, locked4, err_pulse4, err_count4} !== 24'h0) begin
      n_fails++;
      $display("FAIL reset_state got l=%b p=%b c=%0d l4=%b p4=%b c4=%0d want all 0",
               locked, err_pulse, err_count, locked4, err_pulse4, err_count4);
    end
  endtask

  task automatic test_clean_lock();
    int first = 0;
    int pulses = 0;
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      drive(1'b1, nb(), 1'b0);
      if (locked && first == 0) first = i;
      if (err_pulse) pulses++;
      n_checks++;
      if (gotv() !== expv()) begin
        n_fails++;
        $display("FAIL clean_model bit %0d got %h want %h", i, gotv(), expv());
      end
    end
    n_checks++;
    if (first != 12 || pulses != 0 || err_count !== 16'd0) begin
      n_fails++;
      $display("FAIL clean_lock got lock_bit=%0d pulses=%0d cnt=%0d want 12 0 0",
               first, pulses, err_count);
    end
  endtask

  task automatic test_single_error();
    int pulses = 0;
    bit dropped = 0;
    do_reset();
    for (int i = 1; i <= 130; i++) begin
      drive(1'b1, nb() ^ (i == 30), 1'b0);
      if (err_pulse) pulses++;
      if (i > 12 && !locked) dropped = 1;
      n_checks++;
      if (gotv() !== expv()) begin
        n_fails++;
        $display("FAIL single_model bit %0d got %h want %h", i, gotv(), expv());
      end
    end
    n_checks++;
    if (pulses != 1 || err_count !== 16'd1 || dropped) begin
      n_fails++;
      $display("FAIL single_err got pulses=%0d cnt=%0d dropped=%b want 1 1 0",
               pulses, err_count, dropped);
    end
  endtask

  task automatic test_zero_stream();
    bit seen = 0;
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (locked) seen = 1;
    end
    n_checks++;
    if (seen || err_count !== 16'd0 || m_lock) begin
      n_fails++;
      $display("FAIL zero_stream got seen_lock=%b cnt=%0d want 0 0", seen, err_count);
    end
  endtask

  task automatic test_unlock_relock();
    int relock = 0;
    do_reset();
    for (int i = 1; i <= 20; i++) drive(1'b1, nb(), 1'b0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, ~nb(), 1'b0);
      n_checks++;
      if (locked !== (i < 4) || err_count !== 16'(i)) begin
        n_fails++;
        $display("FAIL unlock miss %0d got l=%b cnt=%0d want l=%b cnt=%0d",
                 i, locked, err_count, i < 4, i);
      end
    end
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, nb(), 1'b0);
      if (locked && relock == 0) relock = i;
      n_checks++;
      if (gotv() !== expv()) begin
        n_fails++;
        $display("FAIL relock_model bit %0d got %h want %h", i, gotv(), expv());
      end
    end
    n_checks++;
    if (relock != 12 || err_count !== 16'd4) begin
      n_fails++;
      $display("FAIL relock got bit=%0d cnt=%0d want 12 4", relock, err_count);
    end
  endtask

  task automatic test_valid_toggle();
    int first = -1;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (i % 2 == 0) drive(1'b1, nb(), 1'b0);
      else drive(1'b0, 1'($urandom), 1'b0);
      if (locked && first < 0) first = i;
      n_checks++;
      if (gotv() !== expv()) begin
        n_fails++;
        $display("FAIL toggle_model cyc %0d got %h want %h", i, gotv(), expv());
      end
    end
    n_checks++;
    if (first != 22) begin
      n_fails++;
      $display("FAIL toggle_lock got cyc=%0d want 22", first);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 12; i++) drive(1'b1, nb(), 1'b0);
    for (int e = 0; e < 20; e++) begin
      for (int i = 0; i < 9; i++) drive(1'b1, nb(), 1'b0);
      drive(1'b1, ~nb(), 1'b0);
    end
    n_checks++;
    if (err_count4 !== 4'd15 || err_count !== 16'd20 || !locked) begin
      n_fails++;
      $display("FAIL saturate got c4=%0d c16=%0d l=%b want 15 20 1",
               err_count4, err_count, locked);
    end
    for (int i = 0; i < 9; i++) drive(1'b1, nb(), 1'b0);
    drive(1'b1, ~nb(), 1'b1);
    n_checks++;
    if (err_count4 !== 4'd0 || err_count !== 16'd0 || err_pulse !== 1'b1 ||
        err_pulse4 !== 1'b1 || locked !== 1'b1) begin
      n_fails++;
      $display("FAIL clear_vs_err got c4=%0d c16=%0d p=%b l=%b want 0 0 1 1",
               err_count4, err_count, err_pulse, locked);
    end
    drive(1'b1, ~nb(), 1'b0);
    reset = 1'b1; in_valid = 1'b1; in_bit = ~nb(); clear_errs = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    model_reset();
    n_checks++;
    if (locked !== 1'b0 || err_count !== 16'd0 || err_count4 !== 4'd0 ||
        err_pulse !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_locked got l=%b c=%0d c4=%0d p=%b want 0 0 0 0",
               locked, err_count, err_count4, err_pulse);
    end
  endtask

  task automatic test_random();
    int burst = 0;
    bit v, b, c;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      if (v) begin
        b = nb();
        if (burst > 0) begin
          b = ~b; burst--;
        end else if ($urandom_range(0, 199) == 0) begin
          burst = $urandom_range(4, 6);
        end else if ($urandom_range(0, 39) == 0) begin
          b = ~b;
        end
      end else begin
        b = 1'($urandom);
      end
      drive(v, b, c);
      n_checks++;
      if (gotv() !== expv()) begin
        n_fails++;
        $display("FAIL random_model cyc %0d got %h want %h", i, gotv(), expv());
      end
    end
  endtask

  initial begin
    gi = 0;
    model_reset();
    test_reset();
    test_clean_lock();
    test_single_error();
    test_zero_stream();
    test_unlock_relock();
    test_valid_toggle();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
